// File: rtl/priority_encoder_pkg.sv
// ----------------------------------------------------------------------------
// priority_encoder_pkg
//   Shared constants and types for the 8-to-3 registered priority encoder.
//   IN_WIDTH   : number of request lines
//   CODE_WIDTH : width of the encoded winning index
//   code_t     : encoded index type
// ----------------------------------------------------------------------------
package priority_encoder_pkg;

   localparam int IN_WIDTH   = 8;
   localparam int CODE_WIDTH = 3;

   typedef logic [CODE_WIDTH-1:0] code_t;
   typedef logic [IN_WIDTH-1:0]   req_t;

   // Result of one encode: winning index plus "any request present" flag.
   typedef struct packed {
      code_t code;
      logic  valid;
   } enc_result_t;

   localparam enc_result_t ENC_IDLE = '{code: '0, valid: 1'b0};

endpackage

// File: rtl/priority_encoder_core.sv
// ----------------------------------------------------------------------------
// priority_encoder_core
//   Purely combinational priority encode: the highest set request bit wins.
//   Ports:
//     req_vec  in  [7:0]  request lines, bit 7 = highest priority
//     code     out [2:0]  index of the highest set request bit
//     valid    out        at least one request bit set
// ----------------------------------------------------------------------------
module priority_encoder_core
   import priority_encoder_pkg::*;
(
   input  logic [IN_WIDTH-1:0]   req_vec,
   output logic [CODE_WIDTH-1:0] code,
   output logic                  valid
);

   // Scan from the top down and stop at the first set bit. Lines below the
   // winner are never examined, so unknown values there cannot leak into
   // the code or the valid flag.
   always_comb begin
      code  = '0;
      valid = 1'b0;
      if (req_vec[7]) begin
         code  = 3'd7;
         valid = 1'b1;
      end else if (req_vec[6]) begin
         code  = 3'd6;
         valid = 1'b1;
      end else if (req_vec[5]) begin
         code  = 3'd5;
         valid = 1'b1;
      end else if (req_vec[4]) begin
         code  = 3'd4;
         valid = 1'b1;
      end else if (req_vec[3]) begin
         code  = 3'd3;
         valid = 1'b1;
      end else if (req_vec[2]) begin
         code  = 3'd2;
         valid = 1'b1;
      end else if (req_vec[1]) begin
         code  = 3'd1;
         valid = 1'b1;
      end else if (req_vec[0]) begin
         code  = 3'd0;
         valid = 1'b1;
      end
   end

endmodule

// File: rtl/priority_encoder.sv
// ----------------------------------------------------------------------------
// priority_encoder
//   8-to-3 priority encoder with one registered output stage (1-cycle latency,
//   one result per clock, no handshake).
//   Ports:
//     clk        in   sole clock, rising edge
//     rst        in   synchronous active-high reset, clears code and valid
//     d0..d7     in   request lines, d7 highest priority
//     a, b, c    out  registered winning index, a = MSB, c = LSB
//     valid      out  registered "at least one request" flag
// ----------------------------------------------------------------------------
module priority_encoder
   import priority_encoder_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d0,
   input  logic d1,
   input  logic d2,
   input  logic d3,
   input  logic d4,
   input  logic d5,
   input  logic d6,
   input  logic d7,
   output logic a,
   output logic b,
   output logic c,
   output logic valid
);

   req_t        req_vec;
   code_t       core_code;
   logic        core_valid;
   enc_result_t res_d;
   enc_result_t res_q;

   assign req_vec = {d7, d6, d5, d4, d3, d2, d1, d0};

   priority_encoder_core u_core (
      .req_vec (req_vec),
      .code    (core_code),
      .valid   (core_valid)
   );

   always_comb begin
      res_d       = ENC_IDLE;
      res_d.code  = core_code;
      res_d.valid = core_valid;
   end

   // Reset wins over sampling on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= ENC_IDLE;
      end else begin
         res_q <= res_d;
      end
   end

   assign a     = res_q.code[2];
   assign b     = res_q.code[1];
   assign c     = res_q.code[0];
   assign valid = res_q.valid;

endmodule

// File: tb/tb_priority_encoder.sv
// ----------------------------------------------------------------------------
// tb_priority_encoder
//   Self-checking bench for priority_encoder: directed cases followed by
//   random vectors compared against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_priority_encoder;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       a, b, c, valid;

   int n_assert = 0;
   int n_fail   = 0;

   priority_encoder dut (
      .clk   (clk),
      .rst   (rst),
      .d0    (din[0]),
      .d1    (din[1]),
      .d2    (din[2]),
      .d3    (din[3]),
      .d4    (din[4]),
      .d5    (din[5]),
      .d6    (din[6]),
      .d7    (din[7]),
      .a     (a),
      .b     (b),
      .c     (c),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: index of the highest set bit = floor(log2(v)), by halving.
   // Returns {code, valid}.
   function automatic logic [3:0] model(input int unsigned v);
      int unsigned x;
      int unsigned n;
      if (v == 0) return 4'b000_0;
      x = v;
      n = 0;
      while (x > 1) begin
         x = x / 2;
         n = n + 1;
      end
      return {n[2:0], 1'b1};
   endfunction

   task automatic chk(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {a, b, c, valid};
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got {abc,valid}=%b_%b expected %b_%b",
                tag, obs[3:1], obs[0], exp[3:1], exp[0]);
      end
   endtask

   // Drive a vector, let one rising edge sample it, check 1 ns later.
   task automatic step(input string tag, input logic [7:0] v, input logic [3:0] exp);
      din = v;
      @(posedge clk);
      #1;
      chk(tag, exp);
   endtask

   initial begin
      logic [7:0]  v;
      logic [3:0]  cur;
      int unsigned r;

      rst = 1'b1;
      din = 8'hFF;
      @(posedge clk);
      #1;
      chk("reset_state", 4'b000_0);
      @(posedge clk);
      #1;
      chk("reset_hold", 4'b000_0);

      rst = 1'b0;
      // First edge after release samples normally.
      step("all_zero",  8'h00, 4'b000_0);
      step("only_d0",   8'h01, 4'b000_1);

      for (int n = 0; n < 8; n++) begin
         v = 8'h00;
         v[n] = 1'b1;
         step($sformatf("walk_%0d", n), v, {n[2:0], 1'b1});
      end

      for (int n = 1; n < 8; n++) begin
         v = 'x;
         v[n] = 1'b1;
         for (int k = n + 1; k < 8; k++) v[k] = 1'b0;
         step($sformatf("dontcare_%0d", n), v, {n[2:0], 1'b1});
      end

      step("multi_81", 8'b1000_0001, 4'b111_1);
      step("multi_36", 8'b0011_0110, 4'b101_1);
      step("multi_ff", 8'b1111_1111, 4'b111_1);

      // Inputs changing between edges must not reach the outputs.
      din = 8'b0000_0100;
      #2;
      chk("latency_hold", 4'b111_1);
      @(posedge clk);
      #1;
      chk("latency_update", 4'b010_1);

      // Reset mid-stream with d7 active.
      step("pre_reset_d7", 8'h80, 4'b111_1);
      rst = 1'b1;
      #2;
      chk("rst_between_edges", 4'b111_1);
      @(posedge clk);
      #1;
      chk("rst_edge", 4'b000_0);
      rst = 1'b0;
      #2;
      chk("rst_release_between", 4'b000_0);
      @(posedge clk);
      #1;
      chk("rst_release_edge", 4'b111_1);

      for (int i = 0; i < 48; i++) begin
         r = $urandom_range(0, 255);
         if (i % 6 == 0) r = r >> $urandom_range(1, 7);
         v = r[7:0];
         cur = model(r);
         step($sformatf("rand_%0d_%02h", i, v), v, cur);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
